// File: rtl/vdc_sched_pkg.sv
// rtl/vdc_sched_pkg.sv - shared types and elaboration helpers for the VdC scheduler
//
// Purpose: FSM state and base-select encodings, default per-requester base
// list, and constant functions used to build the per-base scale factors.
// Ports: none (package).
package vdc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Selects one of the constant-divisor units in the digit step.
  typedef enum logic [1:0] {
    SEL_B2 = 2'd0,
    SEL_B3 = 2'd1,
    SEL_B5 = 2'd2,
    SEL_B7 = 2'd3
  } base_sel_e;

  // Requester 0 in the LSBs: dimension bases 2, 3, 5, 7.
  localparam logic [31:0] DEFAULT_BASE_LIST = {8'd7, 8'd5, 8'd3, 8'd2};

  // base^exp, saturating just above 2^32 so an oversized factor stays
  // detectable instead of wrapping back into range.
  function automatic logic [63:0] ipow(input int unsigned base, input int unsigned exp);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < exp; i++) begin
      if (r > 64'h0000_0001_0000_0000) r = 64'h0000_0001_0000_0000;
      else r = r * 64'(base);
    end
    return r;
  endfunction

  function automatic bit is_supported_base(input int unsigned b);
    return (b == 2) || (b == 3) || (b == 5) || (b == 7);
  endfunction

  function automatic base_sel_e base_to_sel(input int unsigned b);
    case (b)
      3:       return SEL_B3;
      5:       return SEL_B5;
      7:       return SEL_B7;
      default: return SEL_B2;
    endcase
  endfunction

endpackage

// File: rtl/vdc_digit_step.sv
// rtl/vdc_digit_step.sv - one base-b digit of the radical inverse, combinational
//
// Purpose: retires the lowest base-b digit of k into the accumulator, weighted
// by the next-lower power of the base (f/b).
// Ports:
//   k_i, f_i, acc_i : current remaining index, weight and partial sum
//   sel_i           : which constant-divisor unit (base 2/3/5/7) to use
//   k_o, f_o, acc_o : next-state values (k/b, f/b, acc + (k%b)*(f/b))
//   done_o          : next k is zero, i.e. this was the last digit
module vdc_digit_step
  import vdc_sched_pkg::*;
(
  input  logic [31:0] k_i,
  input  logic [31:0] f_i,
  input  logic [31:0] acc_i,
  input  base_sel_e   sel_i,
  output logic [31:0] k_o,
  output logic [31:0] f_o,
  output logic [31:0] acc_o,
  output logic        done_o
);

  logic [31:0] base_w;
  logic [31:0] digit_w;

  // Each arm divides by a constant, so no general divider is built; the
  // remainder is recovered from the quotient rather than a second divider.
  always_comb begin
    base_w = 32'd2;
    k_o    = k_i >> 1;
    f_o    = f_i >> 1;
    case (sel_i)
      SEL_B3: begin
        base_w = 32'd3;
        k_o    = k_i / 32'd3;
        f_o    = f_i / 32'd3;
      end
      SEL_B5: begin
        base_w = 32'd5;
        k_o    = k_i / 32'd5;
        f_o    = f_i / 32'd5;
      end
      SEL_B7: begin
        base_w = 32'd7;
        k_o    = k_i / 32'd7;
        f_o    = f_i / 32'd7;
      end
      default: begin
        base_w = 32'd2;
        k_o    = k_i >> 1;
        f_o    = f_i >> 1;
      end
    endcase
    digit_w = k_i - k_o * base_w;
    // Once f has dropped to zero the remaining digits contribute nothing;
    // that is the intended truncation at SCALE digits.
    acc_o   = acc_i + digit_w * f_o;
    done_o  = (k_o == 32'd0);
  end

endmodule

// File: rtl/vdc_sched.sv
// rtl/vdc_sched.sv - round-robin time-shared Van der Corput engine
//
// Purpose: NUM_REQ Halton dimensions share one digit-serial radical-inverse
// engine. Each requester owns a 32-bit index counter; a grant computes
// radical_inverse(count+1) * base^SCALE and the counter advances when the
// response is accepted.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   req / gnt              : level requests, one-cycle one-hot grant pulse
//   rsp_valid / rsp_ready  : response handshake
//   rsp_id, rsp_data,      : owning requester, scaled value, index used
//   rsp_index
//   reseed_en, reseed_id,  : overwrite one requester's counter; aborts that
//   seed                     requester's in-flight work
//   busy                   : engine not idle
module vdc_sched
  import vdc_sched_pkg::*;
#(
  parameter int                   NUM_REQ   = 4,
  parameter int unsigned          SCALE     = 10,
  parameter logic [NUM_REQ*8-1:0] BASE_LIST = DEFAULT_BASE_LIST,
  parameter int                   ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [31:0]        rsp_data,
  output logic [31:0]        rsp_index,
  input  logic               reseed_en,
  input  logic [ID_W-1:0]    reseed_id,
  input  logic [31:0]        seed,
  output logic               busy
);

  logic [31:0] factor_w [NUM_REQ];
  base_sel_e   sel_w    [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_base
    localparam int unsigned BASE   = 32'(BASE_LIST[gi*8 +: 8]);
    localparam logic [63:0] FACTOR = ipow(BASE, SCALE);
    if (!is_supported_base(BASE)) begin : g_bad_base
      $error("vdc_sched: requester base must be 2, 3, 5 or 7");
    end
    if (FACTOR >= 64'h0000_0001_0000_0000) begin : g_bad_factor
      $error("vdc_sched: base^SCALE does not fit in 32 bits");
    end
    assign factor_w[gi] = FACTOR[31:0];
    assign sel_w[gi]    = base_to_sel(BASE);
  end

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     k_q, k_d;
  logic [31:0]     kidx_q, kidx_d;
  logic [31:0]     f_q, f_d;
  logic [31:0]     acc_q, acc_d;
  base_sel_e       sel_q, sel_d;
  logic [31:0]     count_q [NUM_REQ];
  logic [31:0]     count_d [NUM_REQ];

  logic [31:0] step_k, step_f, step_acc;
  logic        step_done;

  vdc_digit_step u_step (
    .k_i    (k_q),
    .f_i    (f_q),
    .acc_i  (acc_q),
    .sel_i  (sel_q),
    .k_o    (step_k),
    .f_o    (step_f),
    .acc_o  (step_acc),
    .done_o (step_done)
  );

  // Round-robin pick: scan offsets from the far end down so the set bit
  // nearest at-or-after the pointer is the last one written.
  logic            found_w;
  logic [ID_W-1:0] cand_w;

  always_comb begin
    found_w = 1'b0;
    cand_w  = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[(int'(ptr_q) + j) % NUM_REQ]) begin
        found_w = 1'b1;
        cand_w  = ID_W'((int'(ptr_q) + j) % NUM_REQ);
      end
    end
  end

  logic reseed_hit;
  assign reseed_hit = reseed_en && (32'(reseed_id) < NUM_REQ);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    k_d     = k_q;
    kidx_d  = kidx_q;
    f_d     = f_q;
    acc_d   = acc_q;
    sel_d   = sel_q;
    count_d = count_q;
    gnt     = '0;

    case (state_q)
      IDLE: begin
        // A reseed aimed at the requester being picked wins over its grant.
        if (found_w && !(reseed_hit && reseed_id == cand_w)) begin
          gnt[cand_w] = 1'b1;
          id_d   = cand_w;
          k_d    = count_q[cand_w] + 32'd1;
          kidx_d = k_d;
          f_d    = factor_w[cand_w];
          acc_d  = '0;
          sel_d  = sel_w[cand_w];
          ptr_d  = (cand_w == ID_W'(NUM_REQ - 1)) ? '0 : cand_w + 1'b1;
          // k wrapped to zero has no digits: the result is ready at once.
          state_d = (k_d == 32'd0) ? RESP : CALC;
        end
      end
      CALC: begin
        k_d   = step_k;
        f_d   = step_f;
        acc_d = step_acc;
        if (step_done) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          count_d[id_q] = kidx_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Applied last so it overrides the accept-time counter update and
    // cancels work belonging to the reseeded requester.
    if (reseed_hit) begin
      count_d[reseed_id] = seed;
      if (state_q != IDLE && reseed_id == id_q) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      k_q     <= '0;
      kidx_q  <= '0;
      f_q     <= '0;
      acc_q   <= '0;
      sel_q   <= SEL_B2;
      for (int i = 0; i < NUM_REQ; i++) count_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      k_q     <= k_d;
      kidx_q  <= kidx_d;
      f_q     <= f_d;
      acc_q   <= acc_d;
      sel_q   <= sel_d;
      count_q <= count_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = acc_q;
  assign rsp_index = kidx_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vdc_sched.sv
// tb/tb_vdc_sched.sv - self-checking bench for vdc_sched against a reference model
module tb_vdc_sched;

  localparam int SCALE = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic [31:0] rsp_index;
  logic        reseed_en = 1'b0;
  logic [1:0]  reseed_id = '0;
  logic [31:0] seed = '0;
  logic        busy;

  vdc_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_index (rsp_index),
    .reseed_en (reseed_en),
    .reseed_id (reseed_id),
    .seed      (seed),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned m_cnt [4];
  int          m_ptr;
  int unsigned bases [4] = '{2, 3, 5, 7};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned upow(input int unsigned b, input int unsigned e);
    longint unsigned r = 1;
    for (int unsigned i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Digit j (from the least significant) of k lands at weight b^(SCALE-1-j);
  // digits beyond SCALE carry no weight.
  function automatic logic [31:0] ref_data(input int unsigned b, input logic [31:0] k);
    longint unsigned kk = 64'(k);
    longint unsigned v = 0;
    int j = 0;
    while (kk != 0) begin
      if (j < SCALE) v = v + (kk % b) * upow(b, SCALE - 1 - j);
      kk = kk / b;
      j++;
    end
    return v[31:0];
  endfunction

  function automatic int ref_digits(input int unsigned b, input logic [31:0] k);
    longint unsigned kk = 64'(k);
    int n = 0;
    while (kk != 0) begin
      kk = kk / b;
      n++;
    end
    return n;
  endfunction

  function automatic int ref_pick(input logic [3:0] m);
    for (int j = 0; j < 4; j++) begin
      if (m[(m_ptr + j) % 4]) return (m_ptr + j) % 4;
    end
    return 0;
  endfunction

  // One full transaction: request, grant, latency, result, optional stall
  // and optional reseed of some other requester while the engine is working.
  task automatic serve(input logic [3:0] mask, input int stall, input int rs_id,
                       input logic [31:0] rs_seed, output logic [31:0] dout);
    int g, n, cyc, lat;
    logic [31:0] k, expd;
    @(negedge clk);
    req = mask;
    rsp_ready = (stall == 0);
    #1;
    n = 0;
    while (gnt == 4'b0 && n < 4) begin
      @(negedge clk);
      #1;
      n++;
    end
    g = ref_pick(mask);
    check("gnt", 32'(gnt), 32'(4'b0001 << g));
    k = m_cnt[g] + 32'd1;
    m_ptr = (g + 1) % 4;
    expd = ref_data(bases[g], k);
    lat = 1 + ref_digits(bases[g], k);
    cyc = 0;
    do begin
      @(negedge clk);
      reseed_en = 1'b0;
      #1;
      cyc++;
      if (cyc == 1 && rs_id >= 0 && rs_id != g && lat >= 2) begin
        reseed_en = 1'b1;
        reseed_id = rs_id[1:0];
        seed = rs_seed;
        m_cnt[rs_id] = rs_seed;
      end
    end while (!rsp_valid && cyc < 40);
    check("latency", cyc, lat);
    check("rsp_id", 32'(rsp_id), g);
    check("rsp_data", rsp_data, expd);
    check("rsp_index", rsp_index, k);
    check("gnt_in_resp", 32'(gnt), 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      check("stall_valid", 32'(rsp_valid), 1);
      check("stall_data", rsp_data, expd);
      check("stall_id", 32'(rsp_id), g);
      check("stall_gnt", 32'(gnt), 0);
      check("stall_busy", 32'(busy), 1);
    end
    rsp_ready = 1'b1;
    m_cnt[g] = k;
    dout = rsp_data;
  endtask

  task automatic reseed_idle(input int id, input logic [31:0] s);
    @(negedge clk);
    req = '0;
    reseed_en = 1'b1;
    reseed_id = id[1:0];
    seed = s;
    m_cnt[id] = s;
    @(negedge clk);
    reseed_en = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] s;
    int rs;

    // Reset
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_id", 32'(rsp_id), 0);
    check("rst_data", rsp_data, 0);
    check("rst_index", rsp_index, 0);
    check("rst_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Base-2 sequence from index 1
    serve(4'b0001, 0, -1, 0, d);
    check("b2_k1", d, 32'd512);
    serve(4'b0001, 0, -1, 0, d);
    check("b2_k2", d, 32'd256);
    serve(4'b0001, 0, -1, 0, d);
    check("b2_k3", d, 32'd768);

    // All requesting: pointer now at 1, so 1,2,3 get their first index
    serve(4'b1111, 0, -1, 0, d);
    check("rr_b3", d, 32'd19683);
    serve(4'b1111, 0, -1, 0, d);
    check("rr_b5", d, 32'd1953125);
    serve(4'b1111, 0, -1, 0, d);
    check("rr_b7", d, 32'd40353607);
    serve(4'b1111, 0, -1, 0, d);
    serve(4'b1111, 0, -1, 0, d);

    // Counter wraps: index 0, no digits, value 0, then restarts at 1
    reseed_idle(0, 32'hFFFF_FFFF);
    serve(4'b0001, 0, -1, 0, d);
    check("wrap_data", d, 32'd0);
    serve(4'b0001, 0, -1, 0, d);
    check("after_wrap", d, 32'd512);

    // Worst-case latency: 32 base-2 digits, all below resolution
    reseed_idle(0, 32'h7FFF_FFFF);
    serve(4'b0001, 0, -1, 0, d);
    check("k_2pow31", d, 32'd0);

    // Back-pressure
    serve(4'b0010, 5, -1, 0, d);

    // Reseed of a different requester while computing
    reseed_idle(2, 32'd1000);
    serve(4'b0100, 0, 3, 32'h0000_1234, d);
    serve(4'b1000, 0, -1, 0, d);
    check("other_reseed_idx", rsp_index, 32'h0000_1235);

    // Reseed of the in-flight requester aborts it
    reseed_idle(2, 32'd1000);
    @(negedge clk);
    req = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    check("abort_gnt", 32'(gnt), 32'(4'b0100));
    m_ptr = 3;
    @(negedge clk);
    req = '0;
    reseed_en = 1'b1;
    reseed_id = 2'd2;
    seed = 32'd41;
    m_cnt[2] = 32'd41;
    #1;
    check("abort_busy_calc", 32'(busy), 1);
    @(negedge clk);
    reseed_en = 1'b0;
    #1;
    check("abort_idle", 32'(busy), 0);
    check("abort_no_rsp", 32'(rsp_valid), 0);
    serve(4'b0100, 0, -1, 0, d);
    check("abort_regrant_idx", rsp_index, 32'd42);

    // Reseed in the same cycle as that requester's grant suppresses it
    @(negedge clk);
    req = 4'b0001;
    reseed_en = 1'b1;
    reseed_id = 2'd0;
    seed = 32'd5;
    m_cnt[0] = 32'd5;
    #1;
    check("supp_gnt", 32'(gnt), 0);
    @(negedge clk);
    req = '0;
    reseed_en = 1'b0;
    #1;
    check("supp_busy", 32'(busy), 0);
    serve(4'b0001, 0, -1, 0, d);
    check("supp_idx", rsp_index, 32'd6);

    // Randomized traffic
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 2))
          0: s = $urandom;
          1: s = 32'hFFFF_FFFF - $urandom_range(0, 3);
          default: s = $urandom_range(0, 50);
        endcase
        reseed_idle($urandom_range(0, 3), s);
      end
      rs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      serve(4'($urandom_range(1, 15)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
            rs, $urandom, d);
    end

    @(negedge clk);
    req = '0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vdc_sched.md
Name: vdc_sched

Overview:
Time-shares one digit-serial Van der Corput (radical-inverse) engine among NUM_REQ requesters. Each requester is one Halton dimension with its own base and its own 32-bit index counter. Grants are round-robin. The engine retires one base-b digit per cycle and returns a 32-bit value scaled by base^SCALE. The block sits between the per-dimension point consumers and the shared arithmetic, replacing per-dimension generator instances.

Parameters:
NUM_REQ, 4, number of requesters/dimensions (2..8)
SCALE, 10, digits of output scale; output = radical_inverse(k) * base^SCALE
BASE_LIST, {8'd7,8'd5,8'd3,8'd2}, packed 8-bit base per requester, index 0 in LSBs; each entry must be in {2,3,5,7}
ID_W, $clog2(NUM_REQ) (min 1), width of requester id

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req  in  NUM_REQ  level request per requester; held until its response is accepted
gnt  out  NUM_REQ  one-cycle one-hot pulse when a requester is taken into the engine
rsp_valid  out  1  result valid; held until rsp_ready
rsp_ready  in  1  consumer accepts result
rsp_id  out  ID_W  requester the result belongs to
rsp_data  out  32  scaled VdC value
rsp_index  out  32  index k used (count+1)
reseed_en  in  1  load seed into count[reseed_id]
reseed_id  in  ID_W  target requester
seed  in  32  new count value
busy  out  1  state != IDLE

Behaviour:
- Reset: gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_index=0, busy=0, all count[i]=0, RR pointer=0, state=IDLE.
- Factor per base: FACTOR[b] = b^SCALE, an elaboration-time constant. Elaboration fails if any FACTOR ≥ 2^32 or any base is not in {2,3,5,7}. Defaults: 1024, 59049, 9765625, 282475249.
- FSM IDLE -> CALC -> RESP -> IDLE.
- IDLE:
  - If any req is set, grant the first set bit at or after the RR pointer, wrapping.
  - Pulse gnt[i]. Latch id=i, k=count[i]+1 (32-bit wrap), kidx=k, f=FACTOR[base(i)], acc=0.
  - RR pointer <= i+1 mod NUM_REQ.
  - Next state is CALC, or RESP directly if k==0.
- CALC, one digit per cycle:
  - f<=f/b; acc<=acc+(k%b)*(f/b); k<=k/b.
  - Go to RESP when the next k==0.
  - Division/modulo use a mux of constant-divisor units selected by base; no generic divider.
  - Latency from the gnt cycle to rsp_valid = 1 + number of base-b digits of k. Worst case is 33 cycles (base 2, k ≥ 2^31).
- RESP:
  - rsp_valid=1; rsp_id, rsp_data=acc, rsp_index=kidx stay stable until rsp_ready.
  - On the valid&ready cycle: count[id]<=kidx, rsp_valid<=0, go to IDLE.
  - No new grant in the accept cycle. Next grant is no earlier than the following cycle.
- Digits below f's resolution: once f reaches 0, further digits add 0. This is the required truncation, not an error.
- Reseed, highest priority, takes effect in any state:
  - count[reseed_id]<=seed.
  - If reseed_id matches the in-flight id while in CALC or RESP: abort, rsp_valid<=0, go to IDLE, no count update, no response. The requester re-arbitrates and gets the index seed+1.
  - If reseed_id matches a requester being granted in that same IDLE cycle: the grant is suppressed.
  - Reseed of a non-in-flight id does not disturb the computation.
- req deasserted after gnt: the computation completes and the response is still presented.
- Unknown/out-of-range reseed_id (≥ NUM_REQ): ignored.

Decomposition:
- Package vdc_sched_pkg:
  - state enum (IDLE, CALC, RESP)
  - constant function ipow(base, exp)
  - default BASE_LIST
  - supported-base check function
- Sub-module vdc_digit_step, combinational:
  - inputs: k, f, acc, base select
  - outputs: next k, next f, next acc, done flag
  - holds the constant-divisor mux.
- Arbiter, counters and FSM stay in vdc_sched.

Test Plan:
- After reset, req=0001, rsp_ready=1 (base 2): gnt=0001, rsp_valid 2 cycles later with data=512, index=1. Next request gives data=256, index=2, then data=768, index=3.
- req=1111 held, rsp_ready=1: grants in order 0,1,2,3,0. First-round data 512, 19683, 1953125, 40353607. No requester starves.
- reseed_en id=0 seed=0xFFFFFFFF then req[0]: index=0, rsp_valid 1 cycle after gnt, data=0. count[0]=0 afterwards, so the next data is 512.
- Base 2, index 0x80000000: rsp_valid exactly 33 cycles after gnt, data=0 (digits below resolution truncated).
- rsp_ready held low 5 cycles during RESP: rsp_valid/id/data stable, no gnt, busy=1. count is unchanged until the accept cycle.
- Reseed of the in-flight id during CALC: no response, state IDLE next cycle. Re-grant returns index seed+1. Reseed of another id mid-CALC: the in-flight result is unchanged.
